mac_acc_stage: RTL and testbench
================================

// Module: mac_acc_stage
// PURPOSE
//  Accumulator stage directly downstream of the 8x8 signed Baugh-Wooley multiplier in each systolic-array PE.
//  Consumes one signed 16-bit product per beat, sign-extends it and sums beats into an ACC_WIDTH register.
//  Presents the finished dot-product result with a valid/ready handshake on the beat marked i_last.
//  Combinational product->adder path; one register stage (accumulator) only.
// PARAMETERS
//  MAC_OUT_WIDTH  16  product width, two's complement (multiplier output width)
//  ACC_WIDTH      24  accumulator/result width; must be >= MAC_OUT_WIDTH
//  CNT_WIDTH      8   beat-counter width
// PORTS
//  i_clk      in   1              clock; single clock domain
//  i_rstn     in   1              reset; asynchronous, active-low
//  i_en_ff    in   1              stage enable; 0 freezes all state
//  i_clear    in   1              synchronous abort/clear of the current dot product
//  i_prod     in   MAC_OUT_WIDTH  signed product from multiplier
//  i_valid    in   1              i_prod valid
//  i_last     in   1              final beat of current dot product (qualified by i_valid)
//  o_ready    out  1              stage can accept a beat this cycle
//  o_acc      out  ACC_WIDTH      signed accumulated result
//  o_valid    out  1              o_acc holds a finished result
//  i_res_rdy  in   1              downstream accepts o_acc
//  o_beats    out  CNT_WIDTH      beats summed into current/held result (saturates at all-ones)
//  o_sat      out  1              sticky: saturation occurred in current/held result
// BEHAVIOUR
//  - Reset (i_rstn=0, async): state=IDLE, o_acc=0, o_valid=0, o_beats=0, o_sat=0.
//  - States: IDLE (no partial sum), ACC (partial sum open), HOLD (result pending; o_valid=1).
//  - o_ready = i_en_ff & ~i_clear & (state!=HOLD | i_res_rdy). accept = i_valid & o_ready.
//  - ext = sign-extended i_prod to ACC_WIDTH.
//  - Start beat (accept in IDLE, or in HOLD with i_res_rdy): acc<=ext, beats<=1, sat<=0; -> HOLD if i_last else ACC.
//  - Continue beat (accept in ACC): acc<=acc+ext, beats<=beats+1 (saturating), sat|=overflow; -> HOLD if i_last else ACC.
//  - HOLD & i_res_rdy & ~accept -> IDLE; o_acc/o_beats/o_sat keep their value, o_valid drops.
//  - HOLD & ~i_res_rdy: all outputs stable; no beat accepted.
//  - ACC & ~i_valid: hold partial sum indefinitely (bubbles allowed).
//  - Latency: result of i_last beat accepted at edge k is visible with o_valid=1 after edge k.
//  - Result-done and new-start in same cycle (HOLD, i_res_rdy, accept): old result consumed, new sum begins; no bubble.
//  - i_clear=1 with i_en_ff=1 (priority over all): -> IDLE, acc=0, beats=0, sat=0, o_valid=0; beat that cycle dropped.
//  - i_en_ff=0: no state change (incl. i_clear ignored); o_ready=0; outputs held.
//  - Reset mid-sum or mid-HOLD: partial/pending result discarded, reset values apply immediately.
// CONFIGURATION
//  - Macro ACC_SATURATION_EN.
//  - Defined: on signed overflow of acc+ext, acc clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); o_sat set sticky.
//  - Undefined: two's-complement wrap at ACC_WIDTH; o_sat tied 0.
//  - Start beats never overflow (ACC_WIDTH >= MAC_OUT_WIDTH).
// TESTING
//  - Reset: assert i_rstn=0 mid-ACC -> o_valid=0, o_acc=0, o_beats=0 same cycle, state IDLE after release.
//  - Dot product: prods 100,-50,16'h8000(-32768),7 with last on 4th, i_res_rdy=1 -> o_acc=-32711 (24'hFF8039), o_beats=4, o_valid 1 cycle.
//  - Backpressure: result pending, i_res_rdy=0 for 5 cycles, i_valid=1 -> o_ready=0, o_acc stable; i_res_rdy=1 -> next beat accepted same cycle, no bubble.
//  - Clear: 3 beats of 1000 then i_clear with i_valid=1,prod=5 -> beat dropped, o_beats=0; next single last beat 5 -> o_acc=5.
//  - Overflow, ACC_WIDTH=16: 32767 then 1 (last) -> with ACC_SATURATION_EN o_acc=32767, o_sat=1; without o_acc=16'h8000, o_sat=0.
//  - Enable: i_en_ff=0 for 3 cycles mid-sum with i_valid=1 -> no accept, state frozen; i_en_ff=1 resumes sum correctly.

Source files
------------

// File: rtl/mac_acc_stage.sv
// Accumulator stage behind the PE multiplier: sums sign-extended products and hands off the dot product via valid/ready.
// Optional clamp-on-overflow arithmetic is enabled by defining ACC_SATURATION_EN (default: two's-complement wrap).
module mac_acc_stage #(
  parameter int MAC_OUT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_en_ff,
  input  logic                     i_clear,
  input  logic [MAC_OUT_WIDTH-1:0] i_prod,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic [ACC_WIDTH-1:0]     o_acc,
  output logic                     o_valid,
  input  logic                     i_res_rdy,
  output logic [CNT_WIDTH-1:0]     o_beats,
  output logic                     o_sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

`ifdef ACC_SATURATION_EN
  // Signed overflow of a+b: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a,
                                   input logic [ACC_WIDTH-1:0] b,
                                   input logic [ACC_WIDTH-1:0] s);
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] clamp_value(input logic neg);
    return neg ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction
`endif

  state_t                 state_r, state_nxt_s;
  logic [ACC_WIDTH-1:0]   acc_r, acc_nxt_s;
  logic [CNT_WIDTH-1:0]   beats_r, beats_nxt_s;
  logic                   sat_r, sat_nxt_s;
  logic                   valid_r, valid_nxt_s;

  logic [ACC_WIDTH-1:0]   ext_s;
  logic [ACC_WIDTH-1:0]   sum_s;
  logic [ACC_WIDTH-1:0]   cont_acc_s;
  logic                   cont_sat_s;
  logic [CNT_WIDTH-1:0]   cont_beats_s;
  logic                   ready_s;
  logic                   accept_s;

  assign ext_s        = ACC_WIDTH'($signed(i_prod));
  assign sum_s        = acc_r + ext_s;
  assign cont_beats_s = (beats_r == CNT_MAX) ? CNT_MAX : beats_r + CNT_ONE;

`ifdef ACC_SATURATION_EN
  logic ovf_s;
  assign ovf_s      = add_ovf(acc_r, ext_s, sum_s);
  // The clamp direction follows the operands' common sign.
  assign cont_acc_s = ovf_s ? clamp_value(acc_r[ACC_WIDTH-1]) : sum_s;
  assign cont_sat_s = sat_r | ovf_s;
`else
  assign cont_acc_s = sum_s;
  assign cont_sat_s = 1'b0;
`endif

  // A pending result blocks new beats unless downstream takes it this same cycle.
  assign ready_s  = i_en_ff & ~i_clear & ((state_r != ST_HOLD) | i_res_rdy);
  assign accept_s = i_valid & ready_s;

  // Next-state and datapath selection.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    beats_nxt_s = beats_r;
    sat_nxt_s   = sat_r;
    valid_nxt_s = valid_r;
    if (!i_en_ff) begin
      state_nxt_s = state_r;
    end else if (i_clear) begin
      state_nxt_s = ST_IDLE;
      acc_nxt_s   = {ACC_WIDTH{1'b0}};
      beats_nxt_s = {CNT_WIDTH{1'b0}};
      sat_nxt_s   = 1'b0;
      valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_ACC: begin
          acc_nxt_s   = cont_acc_s;
          beats_nxt_s = cont_beats_s;
          sat_nxt_s   = cont_sat_s;
        end
        default: begin
          acc_nxt_s   = ext_s;
          beats_nxt_s = CNT_ONE;
          sat_nxt_s   = 1'b0;
        end
      endcase
      state_nxt_s = i_last ? ST_HOLD : ST_ACC;
      valid_nxt_s = i_last;
    end else if ((state_r == ST_HOLD) && i_res_rdy) begin
      state_nxt_s = ST_IDLE;
      valid_nxt_s = 1'b0;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
      acc_r   <= {ACC_WIDTH{1'b0}};
      beats_r <= {CNT_WIDTH{1'b0}};
      sat_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      beats_r <= beats_nxt_s;
      sat_r   <= sat_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign o_ready = ready_s;
  assign o_acc   = acc_r;
  assign o_beats = beats_r;
  assign o_sat   = sat_r;
  assign o_valid = valid_r;

endmodule

// File: tb/tb_mac_acc_stage.sv
// Self-checking bench for mac_acc_stage: vector table, directed corner sequences, randomized run vs a reference model.
module tb_mac_acc_stage;

  logic        clk;
  logic        rstn;
  logic        en, clr, valid, last, rr;
  logic [15:0] prod;
  logic        ready24, valid24, sat24, ready16, valid16, sat16;
  logic [23:0] acc24;
  logic [15:0] acc16;
  logic [7:0]  beats24, beats16;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mac_acc_stage #(.MAC_OUT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut24 (
    .i_clk(clk), .i_rstn(rstn), .i_en_ff(en), .i_clear(clr), .i_prod(prod),
    .i_valid(valid), .i_last(last), .o_ready(ready24), .o_acc(acc24),
    .o_valid(valid24), .i_res_rdy(rr), .o_beats(beats24), .o_sat(sat24));

  mac_acc_stage #(.MAC_OUT_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_en_ff(en), .i_clear(clr), .i_prod(prod),
    .i_valid(valid), .i_last(last), .o_ready(ready16), .o_acc(acc16),
    .o_valid(valid16), .i_res_rdy(rr), .o_beats(beats16), .o_sat(sat16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, clr, valid, last, rr;
    logic [15:0] prod;
    logic        exp_ready;
    logic [23:0] exp_acc;
    logic [7:0]  exp_beats;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  // Reference model: products of the open dot product, plus the visible result.
  int        cur[$];
  bit        m_open, m_pending;
  logic [31:0] v_acc24, v_acc16, v_beats;
  bit        v_sat24, v_sat16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  task automatic set_in(input logic e, input logic c, input logic v, input logic l,
                        input logic r, input logic [15:0] p);
    en = e; clr = c; valid = v; last = l; rr = r; prod = p;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input logic e, input logic c, input logic v, input logic l,
                         input logic r, input logic [15:0] p, input logic xr,
                         input logic [23:0] xa, input logic [7:0] xb, input logic xv);
    vec_t t;
    t.en = e; t.clr = c; t.valid = v; t.last = l; t.rr = r; t.prod = p;
    t.exp_ready = xr; t.exp_acc = xa; t.exp_beats = xb; t.exp_valid = xv;
    vecs.push_back(t);
  endtask

  // Running sum of cur[] with wrap or clamp at width w; returns the low w bits.
  function automatic logic [31:0] fold(input int w, output bit sat);
    longint s = 0;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    longint m  = (longint'(1) <<< w) - 1;
    sat = 1'b0;
    foreach (cur[i]) begin
      s = s + cur[i];
      if (s > hi || s < lo) begin
`ifdef ACC_SATURATION_EN
        s = (s > hi) ? hi : lo;
        sat = 1'b1;
`else
        s = (s > hi) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
`endif
      end
    end
    fold = 32'(s & m);
  endfunction

  initial begin
    logic [15:0] p;
    bit          m_ready;
    bit          s_tmp;
    logic [15:0] exp16_pos, exp16_neg;
    bit          exp16_sat;

    rstn = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("rst_acc",   {8'h00, acc24}, 32'h0);
    check("rst_valid", {31'h0, valid24}, 32'h0);
    check("rst_beats", {24'h0, beats24}, 32'h0);
    check("rst_sat",   {31'h0, sat24}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("rst_ready", {31'h0, ready24}, 32'h1);

    // Dot product, clear, backpressure and enable freeze as a sequential vector table.
    add_vec(1,0,1,0,1,16'd100,   1, 24'd100,    8'd1, 0);
    add_vec(1,0,1,0,1,-16'sd50,  1, 24'd50,     8'd2, 0);
    add_vec(1,0,1,0,1,16'h8000,  1, 24'hFF8032, 8'd3, 0);
    add_vec(1,0,1,1,1,16'd7,     1, 24'hFF8039, 8'd4, 1);
    add_vec(1,0,0,0,1,16'd0,     1, 24'hFF8039, 8'd4, 0);
    add_vec(1,0,0,0,1,16'd0,     1, 24'hFF8039, 8'd4, 0);
    add_vec(1,0,1,0,1,16'd1000,  1, 24'd1000,   8'd1, 0);
    add_vec(1,0,1,0,1,16'd1000,  1, 24'd2000,   8'd2, 0);
    add_vec(1,0,1,0,1,16'd1000,  1, 24'd3000,   8'd3, 0);
    add_vec(1,1,1,0,1,16'd5,     0, 24'd0,      8'd0, 0);
    add_vec(1,0,1,1,0,16'd5,     1, 24'd5,      8'd1, 1);
    for (int i = 0; i < 5; i++)
      add_vec(1,0,1,0,0,16'd9,   0, 24'd5,      8'd1, 1);
    add_vec(1,0,1,0,1,16'd9,     1, 24'd9,      8'd1, 0);
    add_vec(1,0,1,1,1,16'd1,     1, 24'd10,     8'd2, 1);
    add_vec(1,0,1,0,1,16'd3,     1, 24'd3,      8'd1, 0);
    for (int i = 0; i < 3; i++)
      add_vec(0,0,1,0,1,16'd100, 0, 24'd3,      8'd1, 0);
    add_vec(1,0,1,1,1,16'd4,     1, 24'd7,      8'd2, 1);
    add_vec(0,1,1,0,1,16'd4,     0, 24'd7,      8'd2, 1);
    add_vec(1,0,0,0,1,16'd0,     1, 24'd7,      8'd2, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].en, vecs[i].clr, vecs[i].valid, vecs[i].last, vecs[i].rr, vecs[i].prod);
      #1;
      check($sformatf("vec%0d_ready", i), {31'h0, ready24}, {31'h0, vecs[i].exp_ready});
      tick();
      check($sformatf("vec%0d_acc", i),   {8'h00, acc24},   {8'h00, vecs[i].exp_acc});
      check($sformatf("vec%0d_beats", i), {24'h0, beats24}, {24'h0, vecs[i].exp_beats});
      check($sformatf("vec%0d_valid", i), {31'h0, valid24}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_sat", i),   {31'h0, sat24},   32'h0);
    end

    // Reset in the middle of an open sum acts immediately.
    set_in(1,0,1,0,1,16'd5); tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check("midrst_acc",   {8'h00, acc24},   32'h0);
    check("midrst_beats", {24'h0, beats24}, 32'h0);
    check("midrst_valid", {31'h0, valid24}, 32'h0);
    set_in(1,0,0,0,1,16'd0);
    @(negedge clk); rstn = 1'b1;
    set_in(1,0,1,1,1,16'd11); tick();
    check("postrst_acc",   {8'h00, acc24},   32'd11);
    check("postrst_beats", {24'h0, beats24}, 32'd1);
    set_in(1,0,0,0,1,16'd0); tick();

    // Overflow on the 16-bit accumulator, both directions.
`ifdef ACC_SATURATION_EN
    exp16_pos = 16'h7FFF; exp16_neg = 16'h8000; exp16_sat = 1'b1;
`else
    exp16_pos = 16'h8000; exp16_neg = 16'h7FFF; exp16_sat = 1'b0;
`endif
    set_in(1,0,1,0,1,16'h7FFF); tick();
    set_in(1,0,1,1,1,16'h0001); tick();
    check("ovf_pos_acc", {16'h0, acc16}, {16'h0, exp16_pos});
    check("ovf_pos_sat", {31'h0, sat16}, {31'h0, exp16_sat});
    check("ovf_pos_acc24", {8'h00, acc24}, 32'd32768);
    set_in(1,0,1,0,1,16'h8000); tick();
    check("ovf_start_sat", {31'h0, sat16}, 32'h0);
    set_in(1,0,1,1,1,16'hFFFF); tick();
    check("ovf_neg_acc", {16'h0, acc16}, {16'h0, exp16_neg});
    check("ovf_neg_sat", {31'h0, sat16}, {31'h0, exp16_sat});
    set_in(1,0,0,0,1,16'd0); tick();

    // Beat counter saturates at all-ones while the sum keeps going.
    for (int i = 0; i < 260; i++) begin
      set_in(1,0,1,0,1,16'd1); tick();
    end
    check("beats_sat", {24'h0, beats24}, 32'd255);
    check("beats_sat_acc", {8'h00, acc24}, 32'd260);

    // Randomized run against the reference model, starting from a clear.
    set_in(1,1,0,0,1,16'd0); tick();
    cur.delete(); m_open = 0; m_pending = 0;
    v_acc24 = 0; v_acc16 = 0; v_beats = 0; v_sat24 = 0; v_sat16 = 0;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 5))
        0: p = 16'h7FFF;
        1: p = 16'h8000;
        default: p = 16'($urandom);
      endcase
      set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) < 6), p);
      #1;
      m_ready = en && !clr && (!m_pending || rr);
      check("rnd_ready24", {31'h0, ready24}, {31'h0, m_ready});
      check("rnd_ready16", {31'h0, ready16}, {31'h0, m_ready});
      if (en) begin
        if (clr) begin
          cur.delete(); m_open = 0; m_pending = 0;
          v_acc24 = 0; v_acc16 = 0; v_beats = 0; v_sat24 = 0; v_sat16 = 0;
        end else if (valid && m_ready) begin
          if (!m_open) cur.delete();
          cur.push_back(int'($signed(prod)));
          m_open = !last;
          m_pending = last;
          v_acc24 = fold(24, s_tmp); v_sat24 = s_tmp;
          v_acc16 = fold(16, s_tmp); v_sat16 = s_tmp;
          v_beats = (cur.size() > 255) ? 32'd255 : 32'(cur.size());
        end else if (m_pending && rr) begin
          m_pending = 0;
        end
      end
      tick();
      check("rnd_acc24",   {8'h00, acc24},   v_acc24);
      check("rnd_acc16",   {16'h0, acc16},   v_acc16);
      check("rnd_beats",   {24'h0, beats24}, v_beats);
      check("rnd_valid24", {31'h0, valid24}, {31'h0, m_pending});
      check("rnd_valid16", {31'h0, valid16}, {31'h0, m_pending});
      check("rnd_sat24",   {31'h0, sat24},   {31'h0, v_sat24});
      check("rnd_sat16",   {31'h0, sat16},   {31'h0, v_sat16});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
